ch_seq_ctrl: RTL and testbench
==============================

Name: ch_seq_ctrl

Overview:
- Per-shot sequencer for the channel delay counters of the generator; sits between the host register interface and the N channel counter instances.
- Holds staged 16-bit delay codes and copies them into active registers at trigger, so codes are stable during a shot.
- Drives first-charge and start to every enabled channel, collects each channel's output edge, and reports done/timeout status per shot.
- Mode-aware: GZI (i_mod=0) or GVI (i_mod=1).

Parameters:
- N_CH, 4, number of channels sequenced
- DATA_W, 16, delay code width per channel
- CHARGE_CYC, 3, i_clk cycles first-charge is held before start
- TMO_W, 20, timeout counter width

Ports:
- i_clk  in  1  single clock; all logic on posedge
- i_rst  in  1  synchronous reset, active-high
- i_arm  in  1  level; sequencer accepts triggers while high
- i_trig  in  1  single-cycle trigger pulse, already synchronous to i_clk
- i_mod  in  1  0 = GZI, 1 = GVI; sampled at trigger
- i_ch_en  in  N_CH  channel enable mask; sampled at trigger
- i_wr  in  1  staging-register write strobe
- i_wr_addr  in  $clog2(N_CH)  staging register index
- i_wr_data  in  DATA_W  delay code to stage
- i_tmo_limit  in  TMO_W  shot timeout in cycles; 0 disables timeout
- i_ch_out  in  N_CH  channel counter outputs, synchronised
- o_ch_data  out  N_CH*DATA_W  active delay codes, channel k at bits [k*DATA_W +: DATA_W]
- o_first_charge  out  N_CH  first-charge strobe per channel
- o_ch_start  out  N_CH  start level per channel
- o_mod  out  1  latched mode for current shot
- o_fired  out  N_CH  channels whose output edge was seen this shot
- o_busy  out  1  high in CHARGE and RUN
- o_done  out  1  one-cycle pulse when a shot completes
- o_timeout  out  1  sticky; cleared at next accepted trigger or reset
- o_trig_lost  out  1  sticky; trigger arrived while not ARMED; cleared when i_arm goes 0

Behaviour:
- Reset, applied the cycle after i_rst=1:
  - state IDLE
  - all outputs 0
  - staging and active codes 0
  - timeout and charge counters 0
- Staging writes: accepted in any state. Active copy happens only on an accepted trigger.
- Write and trigger in the same cycle: the active copy takes the pre-write staging value; staging takes the new value.
- FSM transitions:
  - IDLE: i_arm=1 -> ARMED.
  - ARMED: i_arm=0 -> IDLE. i_trig=1 -> latch staging->active, i_ch_en->en_q, i_mod->o_mod. Clear o_fired, o_timeout and the timeout counter.
    - en_q==0 -> DONE.
    - else -> CHARGE.
  - CHARGE: o_first_charge=en_q for exactly CHARGE_CYC cycles, then -> RUN.
  - RUN: o_ch_start=en_q (level) and the timeout counter increments each cycle.
    - Rising edge of i_ch_out[k] with en_q[k]=1 sets o_fired[k]. Edge detect uses the previous-cycle register, so an input already high at RUN entry does not count.
    - o_fired==en_q -> DONE. This takes priority over timeout in the same cycle.
    - i_tmo_limit!=0 and counter==i_tmo_limit-1 -> set o_timeout, go to DONE.
  - DONE: o_done=1 for one cycle and o_ch_start drops. Next state: i_arm=1 -> ARMED, else IDLE.
- i_trig outside ARMED is ignored and sets o_trig_lost.
- i_arm falling during CHARGE/RUN does not abort; the shot finishes normally.
- Latency: trigger cycle T gives o_first_charge high at T+1..T+CHARGE_CYC and o_ch_start high from T+CHARGE_CYC+1.
- Timeout counter saturates and never wraps.
- o_ch_data changes only at the trigger cycle.

Optional Feature:
- Macro: CH_SEQ_STAGGER_EN.
- Defined: in RUN, channel k's o_ch_start rises k cycles after RUN entry, to separate channel start edges and limit cross-channel interference. Timeout counting starts at RUN entry regardless.
- Undefined: all enabled starts rise in the same cycle.

Decomposition:
- Shared package ch_seq_pkg:
  - state enum (IDLE, ARMED, CHARGE, RUN, DONE)
  - defaults N_CH_DEF=4, DATA_W_DEF=16, CHARGE_CYC_DEF=3
- One sub-module, ch_seq_shadow: staging plus active register bank with write port and copy strobe.

Test Plan:
- Stage codes 10,20,30,40; arm; trigger with en=4'b1111 -> o_ch_data holds them; first_charge for 3 cycles; start=4'b1111; drive outputs in turn -> o_fired fills; one o_done; state ARMED.
- en=4'b0101; ch1 and ch3 outputs toggle -> o_fired stays 0 on bits 1 and 3; done when ch0 and ch2 fire.
- tmo_limit=50; ch2 never fires -> o_timeout=1 after 50 RUN cycles; o_done pulses; o_fired=4'b1011.
- Trigger and write of addr 0 = 99 in the same cycle -> active ch0 keeps the old code; the next shot uses 99.
- Trigger during RUN -> ignored and o_trig_lost=1. i_arm=0 mid-run -> shot completes, then IDLE. i_rst mid-RUN -> all outputs 0 the next cycle.
- With CH_SEQ_STAGGER_EN defined: start bits rise at RUN+0, +1, +2, +3.

Source files
------------

// File: rtl/ch_seq_pkg.sv
// Shared state encoding and default sizes for the per-shot channel sequencer.
package ch_seq_pkg;

    localparam int unsigned N_CH_DEF       = 4;
    localparam int unsigned DATA_W_DEF     = 16;
    localparam int unsigned CHARGE_CYC_DEF = 3;
    localparam int unsigned TMO_W_DEF      = 20;

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StCharge,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/ch_seq_shadow.sv
// Staging plus active delay-code banks: host writes land in staging at any time,
// and the active bank is refreshed only on the copy strobe.
module ch_seq_shadow
    import ch_seq_pkg::*;
#(
    parameter int unsigned N_CH   = N_CH_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned AW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr,
    input  logic [AW-1:0]            i_wr_addr,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic                     i_copy,
    output logic [N_CH*DATA_W-1:0]   o_active
);

    logic [N_CH-1:0][DATA_W-1:0] stage_q, stage_d;
    logic [N_CH-1:0][DATA_W-1:0] active_q, active_d;

    always_comb begin
        stage_d  = stage_q;
        active_d = active_q;
        for (int k = 0; k < N_CH; k++) begin
            if (i_wr && (i_wr_addr == AW'(k))) begin
                stage_d[k] = i_wr_data;
            end
        end
        // Copy from the registered bank so a same-cycle write only affects the next shot.
        if (i_copy) begin
            active_d = stage_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stage_q  <= '0;
            active_q <= '0;
        end else begin
            stage_q  <= stage_d;
            active_q <= active_d;
        end
    end

    assign o_active = active_q;

endmodule

// File: rtl/ch_seq_ctrl.sv
// Per-shot sequencer for the channel delay counters: latches codes at trigger, runs
// charge/start, collects channel edges. Define CH_SEQ_STAGGER_EN to stagger start edges.
module ch_seq_ctrl
    import ch_seq_pkg::*;
#(
    parameter int unsigned N_CH       = N_CH_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned CHARGE_CYC = CHARGE_CYC_DEF,
    parameter int unsigned TMO_W      = TMO_W_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_arm,
    input  logic                   i_trig,
    input  logic                   i_mod,
    input  logic [N_CH-1:0]        i_ch_en,
    input  logic                   i_wr,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] i_wr_addr,
    input  logic [DATA_W-1:0]      i_wr_data,
    input  logic [TMO_W-1:0]       i_tmo_limit,
    input  logic [N_CH-1:0]        i_ch_out,
    output logic [N_CH*DATA_W-1:0] o_ch_data,
    output logic [N_CH-1:0]        o_first_charge,
    output logic [N_CH-1:0]        o_ch_start,
    output logic                   o_mod,
    output logic [N_CH-1:0]        o_fired,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_timeout,
    output logic                   o_trig_lost
);

    localparam int unsigned AW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned CW = $clog2(CHARGE_CYC + 1);

    state_e            state_q, state_d;
    logic [N_CH-1:0]   en_q, en_d;
    logic              mod_q, mod_d;
    logic [N_CH-1:0]   fired_q, fired_d;
    logic [N_CH-1:0]   fc_q, fc_d;
    logic [N_CH-1:0]   start_q, start_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              lost_q, lost_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [CW-1:0]     chg_cnt_q, chg_cnt_d;
    logic              arm_q;
    logic [N_CH-1:0]   ch_prev_q;
    logic [N_CH-1:0]   rise;
    logic [N_CH-1:0]   stag_mask;
    logic              copy;

    ch_seq_shadow #(
        .N_CH   (N_CH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_shadow (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr      (i_wr),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data),
        .i_copy    (copy),
        .o_active  (o_ch_data)
    );

`ifdef CH_SEQ_STAGGER_EN
    // Channel k starts k cycles into RUN; the RUN cycle index is the timeout counter.
    always_comb begin
        stag_mask = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (state_q == StRun) begin
                stag_mask[k] = (int'(tmo_cnt_q) + 1) >= k;
            end else begin
                stag_mask[k] = (k == 0);
            end
        end
    end
`else
    assign stag_mask = '1;
`endif

    assign rise = i_ch_out & ~ch_prev_q & en_q;

    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        mod_d     = mod_q;
        fired_d   = fired_q;
        fc_d      = '0;
        start_d   = start_q;
        done_d    = 1'b0;
        timeout_d = timeout_q;
        lost_d    = lost_q;
        tmo_cnt_d = tmo_cnt_q;
        chg_cnt_d = chg_cnt_q;
        copy      = 1'b0;

        if (i_trig && (state_q != StArmed)) begin
            lost_d = 1'b1;
        end else if (arm_q && !i_arm) begin
            lost_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (i_arm) state_d = StArmed;
            end
            StArmed: begin
                if (!i_arm) begin
                    state_d = StIdle;
                end else if (i_trig) begin
                    copy      = 1'b1;
                    en_d      = i_ch_en;
                    mod_d     = i_mod;
                    fired_d   = '0;
                    timeout_d = 1'b0;
                    tmo_cnt_d = '0;
                    chg_cnt_d = '0;
                    if (i_ch_en == '0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StCharge;
                        fc_d    = i_ch_en;
                    end
                end
            end
            StCharge: begin
                if (chg_cnt_q == CW'(CHARGE_CYC - 1)) begin
                    state_d = StRun;
                    start_d = en_q & stag_mask;
                end else begin
                    chg_cnt_d = chg_cnt_q + CW'(1);
                    fc_d      = en_q;
                end
            end
            StRun: begin
                fired_d = fired_q | rise;
                start_d = en_q & stag_mask;
                if (tmo_cnt_q != '1) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                if (fired_d == en_q) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    start_d = '0;
                end else if ((i_tmo_limit != '0) && (tmo_cnt_q == i_tmo_limit - TMO_W'(1))) begin
                    state_d   = StDone;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    start_d   = '0;
                end
            end
            StDone: begin
                start_d = '0;
                state_d = i_arm ? StArmed : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StIdle;
            en_q      <= '0;
            mod_q     <= 1'b0;
            fired_q   <= '0;
            fc_q      <= '0;
            start_q   <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            lost_q    <= 1'b0;
            tmo_cnt_q <= '0;
            chg_cnt_q <= '0;
            arm_q     <= 1'b0;
            ch_prev_q <= '0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            mod_q     <= mod_d;
            fired_q   <= fired_d;
            fc_q      <= fc_d;
            start_q   <= start_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            lost_q    <= lost_d;
            tmo_cnt_q <= tmo_cnt_d;
            chg_cnt_q <= chg_cnt_d;
            arm_q     <= i_arm;
            ch_prev_q <= i_ch_out;
        end
    end

    assign o_first_charge = fc_q;
    assign o_ch_start     = start_q;
    assign o_mod          = mod_q;
    assign o_fired        = fired_q;
    assign o_busy         = (state_q == StCharge) || (state_q == StRun);
    assign o_done         = done_q;
    assign o_timeout      = timeout_q;
    assign o_trig_lost    = lost_q;

endmodule

// File: tb/tb_ch_seq_ctrl.sv
// Scoreboard bench for ch_seq_ctrl: shots push expected results, a monitor checks at o_done.
// Staggered start expectations apply when CH_SEQ_STAGGER_EN is defined.
module tb_ch_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm, trig, mod, wr;
    logic [3:0]  ch_en, ch_out;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic [19:0] tmo_limit;
    logic [63:0] ch_data;
    logic [3:0]  first_charge, ch_start, fired;
    logic        o_mod, busy, done, timeout, trig_lost;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    typedef struct {
        logic [3:0]  en;
        logic [3:0]  fired;
        logic        tmo;
        logic [63:0] data;
        logic        mod;
        int          fc_len;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int          fc_len = 0;
    logic [3:0]  fc_mask = '0;
    logic [3:0]  start_seen = '0;
    logic [63:0] d_init, d_new;

    ch_seq_ctrl dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_arm          (arm),
        .i_trig         (trig),
        .i_mod          (mod),
        .i_ch_en        (ch_en),
        .i_wr           (wr),
        .i_wr_addr      (wr_addr),
        .i_wr_data      (wr_data),
        .i_tmo_limit    (tmo_limit),
        .i_ch_out       (ch_out),
        .o_ch_data      (ch_data),
        .o_first_charge (first_charge),
        .o_ch_start     (ch_start),
        .o_mod          (o_mod),
        .o_fired        (fired),
        .o_busy         (busy),
        .o_done         (done),
        .o_timeout      (timeout),
        .o_trig_lost    (trig_lost)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr_code(input logic [1:0] a, input logic [15:0] d);
        wr = 1'b1; wr_addr = a; wr_data = d;
        cyc(1);
        wr = 1'b0;
    endtask

    task automatic push_exp(input logic [3:0] en_v, input logic [3:0] fired_v, input logic tmo_v,
                            input logic [63:0] data_v, input logic mod_v);
        exp_t x;
        x.en = en_v; x.fired = fired_v; x.tmo = tmo_v; x.data = data_v; x.mod = mod_v;
        x.fc_len = (en_v != 4'b0) ? 3 : 0;
        sb.push_back(x);
    endtask

    // Called at a negedge with the DUT in ARMED; returns one cycle after the trigger edge.
    task automatic fire_trig(input logic [3:0] en_v, input logic mod_v);
        trig = 1'b1; ch_en = en_v; mod = mod_v;
        cyc(1);
        trig = 1'b0;
    endtask

    task automatic wait_done(input int target, input string name);
        int i;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt >= target) break;
        end
        check(name, 64'(done_cnt >= target), 64'd1);
    endtask

    // Monitor: accumulates per-shot activity and checks it against the scoreboard at o_done.
    always @(negedge clk) begin
        if (!busy && !done) begin
            fc_len = 0; fc_mask = '0; start_seen = '0;
        end else begin
            if (first_charge != 4'b0) begin
                fc_len++;
                fc_mask |= first_charge;
            end
            start_seen |= ch_start;
        end
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL done_unexpected: got done with empty scoreboard");
            end else begin
                e = sb.pop_front();
                check("sb_fired", 64'(fired), 64'(e.fired));
                check("sb_timeout", 64'(timeout), 64'(e.tmo));
                check("sb_data", ch_data, e.data);
                check("sb_mod", 64'(o_mod), 64'(e.mod));
                check("sb_fc_len", 64'(fc_len), 64'(e.fc_len));
                check("sb_fc_mask", 64'(fc_mask), 64'(e.en));
                check("sb_start_seen", 64'(start_seen), 64'(e.en));
                check("sb_start_drop", 64'(ch_start), 64'd0);
            end
            fc_len = 0; fc_mask = '0; start_seen = '0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] exp_start;
        d_init = {16'd40, 16'd30, 16'd20, 16'd10};
        d_new  = {16'd40, 16'd30, 16'd20, 16'd99};
        rst = 1'b1; arm = 1'b0; trig = 1'b0; mod = 1'b0; wr = 1'b0;
        ch_en = '0; ch_out = '0; wr_addr = '0; wr_data = '0; tmo_limit = '0;
        cyc(2);
        rst = 1'b0;
        check("rst_data", ch_data, 64'd0);
        check("rst_outs", 64'({first_charge, ch_start, fired}), 64'd0);
        check("rst_flags", 64'({o_mod, busy, done, timeout, trig_lost}), 64'd0);

        // Shot 1: all channels, fire in turn.
        wr_code(2'd0, 16'd10);
        wr_code(2'd1, 16'd20);
        wr_code(2'd2, 16'd30);
        wr_code(2'd3, 16'd40);
        arm = 1'b1;
        cyc(1);
        push_exp(4'b1111, 4'b1111, 1'b0, d_init, 1'b1);
        fire_trig(4'b1111, 1'b1);
        check("s1_fc", 64'(first_charge), 64'hF);
        check("s1_data", ch_data, d_init);
        check("s1_busy", 64'(busy), 64'd1);
        cyc(3);
        for (int k = 0; k < 4; k++) begin
`ifdef CH_SEQ_STAGGER_EN
            exp_start = 4'((1 << (k + 1)) - 1);
`else
            exp_start = 4'b1111;
`endif
            check("s1_start", 64'(ch_start), 64'(exp_start));
            check("s1_fc_off", 64'(first_charge), 64'd0);
            ch_out[k] = 1'b1;
            cyc(1);
        end
        wait_done(1, "s1_done");
        ch_out = '0;
        cyc(1);
        check("s1_idle_busy", 64'(busy), 64'd0);

        // Shot 2: only ch0/ch2 enabled; ch1/ch3 toggling must be ignored.
        push_exp(4'b0101, 4'b0101, 1'b0, d_init, 1'b0);
        fire_trig(4'b0101, 1'b0);
        cyc(3);
        ch_out = 4'b1010; cyc(1);
        ch_out = 4'b0000; cyc(1);
        ch_out = 4'b1010; cyc(1);
        check("s2_masked", 64'(fired), 64'd0);
        ch_out = 4'b0101;
        wait_done(2, "s2_done");
        ch_out = '0;
        cyc(1);

        // Shot 3: ch2 silent, timeout after 50 RUN cycles.
        tmo_limit = 20'd50;
        push_exp(4'b1111, 4'b1011, 1'b1, d_init, 1'b0);
        fire_trig(4'b1111, 1'b0);
        cyc(3);
        ch_out = 4'b1011;
        cyc(49);
        check("s3_early", 64'({done, timeout}), 64'd0);
        cyc(1);
        check("s3_tmo", 64'({done, timeout}), 64'b11);
        ch_out = '0;
        tmo_limit = '0;
        cyc(1);
        check("s3_tmo_sticky", 64'(timeout), 64'd1);

        // Shot 4: write ch0=99 in the trigger cycle; active keeps the old code.
        push_exp(4'b0001, 4'b0001, 1'b0, d_init, 1'b0);
        wr = 1'b1; wr_addr = 2'd0; wr_data = 16'd99;
        fire_trig(4'b0001, 1'b0);
        wr = 1'b0;
        check("s4_tmo_clr", 64'(timeout), 64'd0);
        check("s4_data", ch_data, d_init);
        cyc(3);
        ch_out = 4'b0001;
        wait_done(4, "s4_done");
        ch_out = '0;
        cyc(1);

        // Shot 5: new code, trigger during RUN, disarm mid-run, then IDLE.
        push_exp(4'b0001, 4'b0001, 1'b0, d_new, 1'b1);
        fire_trig(4'b0001, 1'b1);
        check("s5_data", ch_data, d_new);
        cyc(3);
        trig = 1'b1;
        cyc(1);
        trig = 1'b0;
        check("s5_lost", 64'(trig_lost), 64'd1);
        arm = 1'b0;
        cyc(1);
        check("s5_lost_clr", 64'(trig_lost), 64'd0);
        check("s5_busy", 64'(busy), 64'd1);
        ch_out = 4'b0001;
        wait_done(5, "s5_done");
        ch_out = '0;
        cyc(1);
        trig = 1'b1;
        cyc(1);
        trig = 1'b0;
        check("s5_idle_lost", 64'({busy, trig_lost}), 64'b01);

        // Shot 6: empty enable mask goes straight to DONE.
        arm = 1'b1;
        cyc(1);
        push_exp(4'b0000, 4'b0000, 1'b0, d_new, 1'b0);
        fire_trig(4'b0000, 1'b0);
        check("s6_done_now", 64'(done), 64'd1);
        wait_done(6, "s6_done");

        // Shot 7: reset in RUN clears everything.
        fire_trig(4'b1111, 1'b1);
        cyc(3);
        ch_out = 4'b0001;
        cyc(1);
        check("s7_fired", 64'(fired), 64'd1);
        rst = 1'b1;
        cyc(1);
        check("s7_rst_data", ch_data, 64'd0);
        check("s7_rst_outs", 64'({first_charge, ch_start, fired}), 64'd0);
        check("s7_rst_flags", 64'({o_mod, busy, done, timeout, trig_lost}), 64'd0);
        rst = 1'b0; ch_out = '0; arm = 1'b0;
        cyc(3);
        check("sb_empty", 64'(sb.size()), 64'd0);
        check("done_count", 64'(done_cnt), 64'd6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
